// File: rtl/gamma_lut_ctrl.sv
// Double-buffered 256-entry gamma LUT on a two-stage pixel stream. The host fills the
// shadow bank; a commit swaps banks at the next frame start so no frame mixes tables.
module gamma_lut_ctrl #(
  parameter int VSYNC_POL = 1,
  parameter int PIPE_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic       cfg_wr_en,
  input  logic [7:0] cfg_wr_addr,
  input  logic [7:0] cfg_wr_data,
  input  logic       cfg_commit,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_Y,
  output logic       cfg_pending,
  output logic       cfg_wr_drop,
  output logic       active_bank,
  output logic       bypass
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << DATA_W;
  // The datapath is built with two stages; any other PIPE_LAT falls back to two.
  localparam int STAGES = (PIPE_LAT == 2) ? PIPE_LAT : 2;
  localparam logic VSYNC_IDLE = (VSYNC_POL != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   active_bank_q, active_bank_d;
  logic   bypass_q, bypass_d;
  logic   vsync_q;
  logic   frame_start_q;
  logic   wr_ok;

  logic [DATA_W-1:0] bank0_mem [DEPTH];
  logic [DATA_W-1:0] bank1_mem [DEPTH];

  logic [STAGES-1:0] vsync_sr_q;
  logic [STAGES-1:0] href_sr_q;
  logic [STAGES-1:0] clken_sr_q;
  logic [DATA_W-1:0] pix_p1_q;
  logic              bank_p1_q;
  logic              bypass_p1_q;
  logic [DATA_W-1:0] lut_rd_p1;
  logic [DATA_W-1:0] pix_p2_q;

  function automatic logic vsync_active(input logic v);
    return (VSYNC_POL != 0) ? v : ~v;
  endfunction

  function automatic logic [DATA_W-1:0] map_pixel(input logic ck, input logic byp,
                                                  input logic [DATA_W-1:0] raw,
                                                  input logic [DATA_W-1:0] lut);
    if (!ck) return '0;
    return byp ? raw : lut;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q       <= VSYNC_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      vsync_q       <= per_frame_vsync;
      frame_start_q <= vsync_active(per_frame_vsync) & ~vsync_active(vsync_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    bypass_d      = bypass_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_commit) state_d = PENDING;
      end
      PENDING: begin
        if (frame_start_q) state_d = SWAP;
      end
      SWAP: begin
        active_bank_d = ~active_bank_q;
        bypass_d      = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      active_bank_q <= 1'b0;
      bypass_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      bypass_q      <= bypass_d;
    end
  end

  // Writes are accepted only in IDLE so the bank about to go live is never disturbed.
  assign wr_ok       = rst_n & cfg_wr_en & (state_q == IDLE);
  assign cfg_wr_drop = rst_n & cfg_wr_en & (state_q != IDLE);
  assign cfg_pending = (state_q != IDLE);
  assign active_bank = active_bank_q;
  assign bypass      = bypass_q;

  always_ff @(posedge clk) begin
    if (wr_ok && !active_bank_q) bank1_mem[cfg_wr_addr] <= cfg_wr_data;
    if (wr_ok &&  active_bank_q) bank0_mem[cfg_wr_addr] <= cfg_wr_data;
  end

  assign lut_rd_p1 = bank_p1_q ? bank1_mem[pix_p1_q] : bank0_mem[pix_p1_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_sr_q  <= '0;
      href_sr_q   <= '0;
      clken_sr_q  <= '0;
      pix_p1_q    <= '0;
      bank_p1_q   <= 1'b0;
      bypass_p1_q <= 1'b1;
      pix_p2_q    <= '0;
    end else begin
      // Stage 1: capture address plus the bank/bypass choice, pinning the pixel to a table.
      vsync_sr_q  <= {vsync_sr_q[STAGES-2:0], per_frame_vsync};
      href_sr_q   <= {href_sr_q[STAGES-2:0], per_frame_href};
      clken_sr_q  <= {clken_sr_q[STAGES-2:0], per_frame_clken};
      pix_p1_q    <= per_img_Y;
      bank_p1_q   <= active_bank_q;
      bypass_p1_q <= bypass_q;
      // Stage 2: registered LUT read, gated by the delayed clken.
      pix_p2_q    <= map_pixel(clken_sr_q[0], bypass_p1_q, pix_p1_q, lut_rd_p1);
    end
  end

  assign post_frame_vsync = vsync_sr_q[STAGES-1];
  assign post_frame_href  = href_sr_q[STAGES-1];
  assign post_frame_clken = clken_sr_q[STAGES-1];
  assign post_img_Y       = pix_p2_q;

endmodule

// File: doc/gamma_lut_ctrl.md
GAMMA_LUT_CTRL -- requirements
Module: gamma_lut_ctrl

Interface
REQ-001 The block SHALL have parameter VSYNC_POL, default 1, meaning 1 = per_frame_vsync active-high and 0 = active-low.
REQ-002 The block SHALL have parameter PIPE_LAT, default 2, meaning pixel path latency in clk cycles; only the value 2 is supported.
REQ-003 The block SHALL have one clock and a synchronous active-low reset: clk is the sole clock, and rst_n is a synchronous, active-low reset.
REQ-004 The block SHALL provide ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  sync reset, active-low
- per_frame_vsync  in  1  input frame sync
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel valid
- per_img_Y  in  8  input pixel
- cfg_wr_en  in  1  shadow-table write strobe
- cfg_wr_addr  in  8  table index
- cfg_wr_data  in  8  table entry
- cfg_commit  in  1  pulse: request bank swap at next frame start
- post_frame_vsync  out  1  delayed vsync
- post_frame_href  out  1  delayed href
- post_frame_clken  out  1  delayed clken
- post_img_Y  out  8  gamma-mapped pixel
- cfg_pending  out  1  commit waiting for frame start
- cfg_wr_drop  out  1  one-cycle pulse: write rejected
- active_bank  out  1  bank currently used by the pixel path
- bypass  out  1  1 = pixel passed unmapped

Function
REQ-005 Storage SHALL be two 256x8 banks; the pixel path SHALL read only active_bank, and host writes SHALL target only bank ~active_bank (shadow).
REQ-006 The FSM SHALL have states IDLE, PENDING and SWAP; after reset it SHALL be in IDLE.
REQ-007 In IDLE, cfg_wr_en SHALL write cfg_wr_data to shadow[cfg_wr_addr] in that cycle.
REQ-008 In IDLE, cfg_commit SHALL move the FSM to PENDING next cycle; if cfg_wr_en coincides with cfg_commit, the write SHALL complete first.
REQ-009 In PENDING, cfg_wr_en SHALL be ignored, with cfg_wr_drop=1 for that cycle, and cfg_commit SHALL be ignored.
REQ-010 Frame start SHALL be the registered detection of the active edge of per_frame_vsync (polarity per VSYNC_POL), asserted one cycle after the edge appears on the input.
REQ-011 PENDING SHALL go to SWAP on a frame-start detection; a frame start coinciding with the IDLE->PENDING transition SHALL NOT trigger the swap, which waits for the next frame start.
REQ-012 In SWAP, for exactly one cycle, the block SHALL toggle active_bank, clear bypass, and return to IDLE.
REQ-013 cfg_pending SHALL be 1 exactly while the state is PENDING or SWAP.
REQ-014 The pixel path SHALL be stage 1: registered address/sync capture; stage 2: registered LUT read.
- post_* SHALL equal per_* delayed by exactly 2 cycles.
- post_img_Y SHALL be 0 when the delayed clken is 0.
REQ-015 A pixel sampled in the cycle after SWAP or later SHALL use the new bank; an earlier pixel SHALL use the old bank, so a frame is never split between banks.
REQ-016 When bypass=1, post_img_Y SHALL equal per_img_Y delayed 2 cycles (clken-gated as in REQ-014).
REQ-017 There SHALL be no handshake on the pixel path; the block SHALL accept one pixel per cycle without stalls.

Reset
REQ-018 While rst_n=0 at a clk edge, the block SHALL set all post_* outputs to 0, cfg_pending=0, cfg_wr_drop=0, active_bank=0, bypass=1 and the FSM to IDLE, and SHALL flush the pipeline.
REQ-019 Reset SHALL NOT clear bank contents; an in-flight commit SHALL be discarded, and bypass=1 SHALL remain until the next completed swap.
REQ-020 Reset asserted during PENDING SHALL leave active_bank=0 and SHALL NOT perform the swap.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Post-reset stream 0x00..0xFF, clken=1 -> post_img_Y equals input 2 cycles later, bypass=1.
- Write gamma-2.2 table (0x80->0x38, 0xFF->0xFF, 0x10->0x01), commit, then a vsync edge -> cfg_pending 1->0; next frame input 0x80 gives 0x38; active_bank=1, bypass=0.
- Commit mid-frame with pixels flowing -> all pixels of the current frame mapped by the old bank/bypass; new mapping from the first pixel after the edge.
- cfg_wr_en during PENDING -> cfg_wr_drop=1 pulse, shadow entry unchanged, verified by readback after the next swap.
- cfg_commit in the same cycle as vsync edge detection -> no swap at that edge; swap at the following edge.
- rst_n=0 while PENDING -> active_bank=0, bypass=1, cfg_pending=0; following frames pass unmapped.
